// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter feeding a shared, stallable fixed-latency delay line.
// Each entry carries its requester index so the response routes back to its source.
module shift_reg_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 4,
    parameter int unsigned MaxInFlight = 2,
    localparam int unsigned IdxWidth   = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntWidth   = $clog2(Depth + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clr_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_data_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [IdxWidth-1:0]                 rsp_idx_o,
    output logic [DataWidth-1:0]                rsp_data_o,
    output logic [CntWidth-1:0]                 in_flight_o,
    output logic                                idle_o
);

    logic [Depth-1:0]     stage_valid;
    logic [IdxWidth-1:0]  stage_idx  [Depth];
    logic [DataWidth-1:0] stage_data [Depth];
    logic [CntWidth-1:0]  cnt        [NumReq];
    logic [IdxWidth-1:0]  ptr;

    logic                 block;
    logic                 advance;
    logic                 rsp_fire;
    logic                 accept;
    logic                 grant_found;
    logic [IdxWidth-1:0]  grant;
    logic [NumReq-1:0]    eligible;
    logic [IdxWidth:0]    cand_sum;
    logic [IdxWidth-1:0]  cand;

    assign block       = clr_i | rst_i;
    assign advance     = !stage_valid[Depth-1] || rsp_ready_i;
    assign rsp_valid_o = stage_valid[Depth-1] && !block;
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;
    assign rsp_idx_o   = stage_idx[Depth-1];
    assign rsp_data_o  = stage_data[Depth-1];
    assign accept      = grant_found && advance && !block;
    assign idle_o      = (in_flight_o == '0);

    // A requester at its limit may still issue in the cycle one of its own responses leaves.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] &&
                          ((cnt[i] < CntWidth'(MaxInFlight)) ||
                           (rsp_fire && (rsp_idx_o == IdxWidth'(i))));
        end
    end

    // First eligible index at or after ptr, wrapping modulo NumReq.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand_sum = {1'b0, ptr} + (IdxWidth + 1)'(k);
            if (cand_sum >= (IdxWidth + 1)'(NumReq)) begin
                cand_sum = cand_sum - (IdxWidth + 1)'(NumReq);
            end
            cand = cand_sum[IdxWidth-1:0];
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    always_comb begin
        in_flight_o = '0;
        for (int unsigned s = 0; s < Depth; s++) begin
            in_flight_o = in_flight_o + CntWidth'(stage_valid[s]);
        end
    end

    // Line, counters and pointer; clear keeps ptr so fairness survives a flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            stage_valid <= '0;
            for (int unsigned s = 0; s < Depth; s++) begin
                stage_idx[s]  <= '0;
                stage_data[s] <= '0;
            end
            for (int unsigned i = 0; i < NumReq; i++) begin
                cnt[i] <= '0;
            end
            if (rst_i) begin
                ptr <= '0;
            end
        end else begin
            if (advance) begin
                for (int unsigned s = 1; s < Depth; s++) begin
                    stage_valid[s] <= stage_valid[s-1];
                    stage_idx[s]   <= stage_idx[s-1];
                    stage_data[s]  <= stage_data[s-1];
                end
                stage_valid[0] <= accept;
                stage_idx[0]   <= accept ? grant : '0;
                stage_data[0]  <= accept ? req_data_i[grant] : '0;
            end
            if (accept) begin
                ptr <= (grant == IdxWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
            end
            for (int unsigned i = 0; i < NumReq; i++) begin
                if ((accept && grant == IdxWidth'(i)) &&
                    !(rsp_fire && rsp_idx_o == IdxWidth'(i))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!(accept && grant == IdxWidth'(i)) &&
                             (rsp_fire && rsp_idx_o == IdxWidth'(i))) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule
